// File: rtl/divr_operand_packer.sv
// Byte-serial operand front end for the SRT-2 divider: assembles 8-byte frames
// into {sign, dividend, divisor} words and queues them in a first-word-fall-through FIFO.
module divr_operand_packer #(
    parameter int DATA_WIDTH       = 65,
    parameter int BUFFER_DEPTH     = 4,
    parameter int LOG_BUFFER_DEPTH = 3,
    parameter int WIDTH            = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_in_in,
    input  logic                  push_in,
    input  logic                  sign,
    input  logic                  flush,
    output logic                  op_valid,
    output logic [DATA_WIDTH-1:0] op_data,
    input  logic                  op_ready,
    output logic [2:0]            byte_cnt,
    output logic                  fifo_full,
    output logic                  ovf_err
);
    localparam int SR_W  = 2 * WIDTH;
    localparam int IDX_W = LOG_BUFFER_DEPTH - 1;
    localparam logic [2:0] LAST_BYTE = 3'(SR_W / 8 - 1);
    localparam logic [LOG_BUFFER_DEPTH-1:0] PTR_ONE = LOG_BUFFER_DEPTH'(1);

    logic                        r_push_d;
    logic [2:0]                  r_byte_cnt;
    logic [SR_W-1:0]             r_asm_sr;
    logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
    logic                        r_ovf;
    logic [DATA_WIDTH-1:0]       r_mem [BUFFER_DEPTH];

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] w_wr_word;

    assign w_accept   = push_in & ~r_push_d & ~flush;
    assign w_complete = w_accept & (r_byte_cnt == LAST_BYTE);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                        (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    // flush outranks a pop; a full FIFO can still take a word when the head leaves
    assign w_pop      = ~w_empty & op_ready & ~flush;
    assign w_wr_en    = w_complete & (~w_full | w_pop);
    assign w_wr_word  = {sign, r_asm_sr[SR_W-9:0], data_in_in};

    // push_d resets high so a strobe already asserted at reset release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_d   <= 1'b1;
            r_byte_cnt <= 3'd0;
            r_asm_sr   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_push_d <= push_in;
            if (flush) begin
                r_byte_cnt <= 3'd0;
                r_asm_sr   <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_ovf      <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_asm_sr   <= {r_asm_sr[SR_W-9:0], data_in_in};
                    r_byte_cnt <= w_complete ? 3'd0 : r_byte_cnt + 3'd1;
                end
                if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_complete && !w_wr_en) r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_wr_word;
    end

    assign op_valid  = ~w_empty;
    assign op_data   = r_mem[r_rd_ptr[IDX_W-1:0]];
    assign byte_cnt  = r_byte_cnt;
    assign fifo_full = w_full;
    assign ovf_err   = r_ovf;
endmodule

// File: tb/tb_divr_operand_packer.sv
// Randomized scenario bench for divr_operand_packer against a queue-based frame model.
module tb_divr_operand_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data_in_in = 8'h00;
    logic        push_in = 1'b0;
    logic        sign = 1'b0;
    logic        flush = 1'b0;
    logic        op_ready = 1'b0;
    logic        op_valid;
    logic [64:0] op_data;
    logic [2:0]  byte_cnt;
    logic        fifo_full;
    logic        ovf_err;

    int errors = 0;
    int checks = 0;
    logic [64:0] model_q[$];
    logic        model_ovf = 1'b0;
    logic [7:0]  fb[8];

    divr_operand_packer dut (
        .clk(clk), .rst_n(rst_n), .data_in_in(data_in_in), .push_in(push_in),
        .sign(sign), .flush(flush), .op_valid(op_valid), .op_data(op_data),
        .op_ready(op_ready), .byte_cnt(byte_cnt), .fifo_full(fifo_full), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    function automatic logic [64:0] frame_word(input logic s, input logic [7:0] b[8]);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < 8; i++) v = (v << 8) | 64'(b[i]);
        return {s, v};
    endfunction

    // One strobe: push_in high for 'hold' edges then low for one edge.
    task automatic push_byte(input logic [7:0] b, input logic s, input int hold, input logic rdy);
        @(negedge clk);
        data_in_in = b; sign = s; push_in = 1'b1; op_ready = rdy;
        @(negedge clk);
        op_ready = 1'b0;
        repeat (hold - 1) @(negedge clk);
        push_in = 1'b0;
    endtask

    // Random frame with op_ready low; sign on bytes 1-7 is noise, only byte 8 counts.
    task automatic send_frame(input logic s);
        for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++)
            push_byte(fb[i], (i == 7) ? s : 1'($urandom_range(0, 1)), 1, 1'b0);
        if (model_q.size() < 4) model_q.push_back(frame_word(s, fb));
        else model_ovf = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({op_valid, fifo_full, byte_cnt, ovf_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b f=%b cnt=%0d ovf=%b, want all 0",
                     op_valid, fifo_full, byte_cnt, ovf_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] b[8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h01, 8'h23};
        for (int i = 0; i < 7; i++) push_byte(b[i], 1'b0, 1, 1'b0);
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL basic_early_valid: got %b want 0", op_valid);
        end
        push_byte(b[7], 1'b0, 1, 1'b0);
        model_q.push_back(frame_word(1'b0, b));
        checks++;
        if (op_valid !== 1'b1 || op_data !== 65'h0_12345678_00000123 || byte_cnt !== 3'd0) begin
            errors++;
            $display("FAIL basic_frame: got v=%b data=%h cnt=%0d want v=1 data=0_12345678_00000123 cnt=0",
                     op_valid, op_data, byte_cnt);
        end
        for (int k = 0; k < 1; k++) begin
            @(negedge clk);
            op_ready = 1'b1;
            void'(model_q.pop_front());
        end
        @(negedge clk);
        op_ready = 1'b0;
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL basic_pop_empty: got v=%b want 0", op_valid);
        end
    endtask

    task automatic test_hold();
        logic [7:0] b[8] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h03};
        for (int i = 0; i < 8; i++) begin
            push_byte(b[i], 1'b1, 5, 1'b0);
            checks++;
            if (byte_cnt !== 3'((i + 1) % 8)) begin
                errors++; $display("FAIL hold_cnt: byte %0d got cnt=%0d want %0d", i, byte_cnt, (i + 1) % 8);
            end
        end
        model_q.push_back(frame_word(1'b1, b));
        checks++;
        if (op_valid !== 1'b1 || op_data !== 65'h1_FFFFFFFF_00000003) begin
            errors++; $display("FAIL hold_data: got v=%b data=%h want v=1 data=1_ffffffff_00000003", op_valid, op_data);
        end
        @(negedge clk);
        op_ready = 1'b1;
        void'(model_q.pop_front());
        @(negedge clk);
        op_ready = 1'b0;
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL hold_single_frame: got v=%b want 0", op_valid);
        end
    endtask

    task automatic test_overflow();
        for (int f = 0; f < 5; f++) begin
            send_frame(1'($urandom_range(0, 1)));
            checks++;
            if (fifo_full !== (model_q.size() == 4) || ovf_err !== model_ovf || byte_cnt !== 3'd0) begin
                errors++;
                $display("FAIL ovf_frame%0d: got full=%b ovf=%b cnt=%0d want full=%b ovf=%b cnt=0",
                         f + 1, fifo_full, ovf_err, byte_cnt, model_q.size() == 4, model_ovf);
            end
        end
        checks++;
        if (ovf_err !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b want 1", ovf_err);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (op_valid !== 1'b1 || op_data !== model_q[0]) begin
                errors++; $display("FAIL ovf_drain%0d: got v=%b data=%h want v=1 data=%h", k, op_valid, op_data, model_q[0]);
            end
            op_ready = 1'b1;
            void'(model_q.pop_front());
        end
        @(negedge clk);
        op_ready = 1'b0;
        checks++;
        if (op_valid !== 1'b0 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL ovf_drained: got v=%b full=%b want 0 0", op_valid, fifo_full);
        end
    endtask

    task automatic test_flush();
        logic [64:0] exp;
        for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(0, 255)), 1'b0, 1, 1'b0);
        @(negedge clk);
        data_in_in = 8'hA5; push_in = 1'b1; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; push_in = 1'b0;
        model_ovf = 1'b0;
        checks++;
        if (byte_cnt !== 3'd0 || ovf_err !== 1'b0 || op_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got cnt=%0d ovf=%b v=%b want 0 0 0", byte_cnt, ovf_err, op_valid);
        end
        send_frame(1'b1);
        exp = frame_word(1'b1, fb);
        checks++;
        if (op_valid !== 1'b1 || op_data !== exp) begin
            errors++; $display("FAIL flush_reassemble: got v=%b data=%h want v=1 data=%h", op_valid, op_data, exp);
        end
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_q.delete();
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL flush_fifo: got v=%b want 0", op_valid);
        end
    endtask

    task automatic test_pop_write();
        logic s;
        for (int f = 0; f < 4; f++) send_frame(1'($urandom_range(0, 1)));
        checks++;
        if (fifo_full !== 1'b1) begin
            errors++; $display("FAIL popwr_full: got %b want 1", fifo_full);
        end
        s = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) fb[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 7; i++) push_byte(fb[i], 1'b0, 1, 1'b0);
        push_byte(fb[7], s, 1, 1'b1);
        void'(model_q.pop_front());
        model_q.push_back(frame_word(s, fb));
        checks++;
        if (ovf_err !== 1'b0 || fifo_full !== 1'b1) begin
            errors++; $display("FAIL popwr_flags: got ovf=%b full=%b want 0 1", ovf_err, fifo_full);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (op_valid !== 1'b1 || op_data !== model_q[0]) begin
                errors++; $display("FAIL popwr_drain%0d: got v=%b data=%h want v=1 data=%h", k, op_valid, op_data, model_q[0]);
            end
            op_ready = 1'b1;
            void'(model_q.pop_front());
        end
        @(negedge clk);
        op_ready = 1'b0;
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("FAIL popwr_empty: got v=%b want 0", op_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [64:0] exp;
        send_frame(1'b0);
        send_frame(1'b1);
        for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)), 1'b0, 1, 1'b0);
        checks++;
        if (byte_cnt !== 3'd5 || op_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got cnt=%0d v=%b want 5 1", byte_cnt, op_valid);
        end
        @(posedge clk);
        #2;
        push_in = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (op_valid !== 1'b0 || byte_cnt !== 3'd0 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got v=%b cnt=%0d full=%b want 0 0 0", op_valid, byte_cnt, fifo_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        repeat (2) @(negedge clk);
        checks++;
        if (byte_cnt !== 3'd0 || op_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_held_push: got cnt=%0d v=%b want 0 0", byte_cnt, op_valid);
        end
        push_in = 1'b0;
        send_frame(1'b1);
        exp = frame_word(1'b1, fb);
        checks++;
        if (op_valid !== 1'b1 || op_data !== exp) begin
            errors++; $display("FAIL rstmid_next_frame: got v=%b data=%h want v=1 data=%h", op_valid, op_data, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_flush();
        test_pop_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divr_operand_packer.md
# divr_operand_packer

Byte-serial operand front end for the SRT-2 divider core. It accepts a frame of eight bytes over the 8-bit pad bus: dividend MSB-first, then divisor MSB-first, one byte per rising edge of `push_in`. It packs each frame with the `sign` mode bit into one DATA_WIDTH-bit operand word and queues the words in a BUFFER_DEPTH-entry FIFO. The FIFO's first-word-fall-through head feeds the divider core through a valid/ready handshake.

## Interface
- DATA_WIDTH, 65, operand word width: {sign, dividend[WIDTH-1:0], divisor[WIDTH-1:0]}; must equal 2*WIDTH+1
- BUFFER_DEPTH, 4, FIFO entries; power of two
- LOG_BUFFER_DEPTH, 3, pointer width = log2(BUFFER_DEPTH)+1 (MSB is wrap bit)
- WIDTH, 32, operand width in bits; must be a multiple of 8
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- data_in_in  in  8  operand byte, sampled on the accepting edge
- push_in  in  1  byte strobe, synchronous to clk; each 0->1 transition accepts one byte
- sign  in  1  1 = signed division; sampled with byte 8 of the frame
- flush  in  1  synchronous clear of the frame assembly and the FIFO
- op_valid  out  1  FIFO not empty
- op_data  out  DATA_WIDTH  head entry, valid while op_valid=1
- op_ready  in  1  divider core accepts the head this cycle
- byte_cnt  out  3  bytes received of the current frame (0..7)
- fifo_full  out  1  FIFO holds BUFFER_DEPTH entries
- ovf_err  out  1  sticky: at least one complete frame was dropped

## Operation
- Edge detect: push_d <= push_in. accept = push_in & ~push_d & ~flush.
- On accept:
  - asm_sr <= {asm_sr[55:0], data_in_in}, the 64-bit shift register.
  - byte_cnt <= byte_cnt+1. It wraps from 7 to 0 at frame completion.
- Frame complete when accept occurs with byte_cnt==7:
  - wr_word = {sign, asm_sr[55:0], data_in_in}.
  - Bits [63:32] hold the dividend; bits [31:0] hold the divisor.
- Write enable:
  - wr_en = complete & (~fifo_full | pop).
  - If complete & fifo_full & ~pop, the word is discarded and ovf_err <= 1.
  - byte_cnt still returns to 0 on a discarded frame.
- pop = op_valid & op_ready. The read pointer advances on pop.
- Pointers:
  - Write and read pointers are LOG_BUFFER_DEPTH bits wide; the low bits index mem.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
- op_data = mem[rd_ptr low bits], combinational from the registers. It is undefined (don't-care) when op_valid=0.
- No data checking. A zero divisor, signed overflow and similar cases pass through untouched; the core handles them.
- flush=1:
  - Next edge: byte_cnt=0, both pointers=0, asm_sr=0.
  - ovf_err is cleared.
  - Any push edge coincident with flush is ignored.
  - flush has priority over pop and write.

## Timing
- Reset (asynchronous, rst_n=0):
  - Outputs: op_valid=0, fifo_full=0, byte_cnt=0, ovf_err=0.
  - State: pointers=0, asm_sr=0.
  - push_d=1, so a push_in already high at reset release does not count as an edge.
- Byte acceptance: the byte is captured on the first posedge where push_in=1 and push_d=0. Holding push_in high for N cycles accepts exactly one byte.
- The minimum strobe spacing is 2 cycles (0->1->0->1). Back-to-back frames need no gap.
- Latency: op_valid rises on the posedge that captures byte 8. It is visible 1 cycle after that edge, with op_data stable.
- Pop: the head is consumed at the posedge where op_valid & op_ready. The next entry, or op_valid=0, appears the same cycle after.
- Simultaneous pop and write:
  - When full: the write succeeds, the count is unchanged and fifo_full stays 1.
  - When empty: no pop is possible (op_valid=0); the write proceeds.
- Reset mid-frame discards the partial frame and all queued entries. The divider sees op_valid fall asynchronously.
- Counter and pointer wrap-around follows natural binary rollover; no saturation.

## Test plan
- Reset, then frame bytes 0x12,0x34,0x56,0x78,0x00,0x00,0x01,0x23 with sign=0:
  - op_valid=1 one cycle after byte 8.
  - op_data = 0x0_12345678_00000123.
  - byte_cnt returns to 0.
- push_in held high 5 cycles per byte, sign=1, bytes 0xFF×4 then 0x00,0x00,0x00,0x03:
  - Exactly one frame is queued: op_data = 0x1_FFFFFFFF_00000003.
  - byte_cnt steps once per strobe.
- op_ready=0, 5 frames sent:
  - Frames 1-4 are queued and fifo_full=1 after frame 4.
  - Frame 5 is dropped and ovf_err=1.
  - Raising op_ready pops frames 1-4 in order; op_valid falls after the 4th pop.
- FIFO full with op_ready=1 on the cycle byte 8 of frame 5 is accepted:
  - Frame 1 is popped and frame 5 is written.
  - ovf_err stays 0 and fifo_full stays 1.
- 3 bytes pushed then flush=1 together with a push edge:
  - byte_cnt=0 and the push is ignored.
  - The next 8-byte frame assembles correctly from its own bytes only.
- rst_n pulsed low mid-frame (byte_cnt=5) with 2 entries queued:
  - op_valid=0 and byte_cnt=0 immediately.
  - push_in high across reset release does not register a byte.
